// File: rtl/gcd_axi_pkg.sv
// Shared constants and types for the GCD AXI data path.
// Both the burst loader and its skid buffer import this package.
package gcd_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // 1279-bit operands and 1284-bit results, carried in 64-bit beats
  localparam int ARG_BEATS = 20;
  localparam int RES_BEATS = 21;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_WD, ST_WB, ST_AR, ST_RD, ST_RPT
  } loader_state_t;

  // The numeric encoding already orders severity: DECERR > SLVERR > EXOKAY > OKAY
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gcd_axi_skid.sv
// Two-entry valid/ready buffer between the local source stream and the W channel.
// Push and pop in the same cycle leave the occupancy unchanged.
module gcd_axi_skid
  import gcd_axi_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        full,
  output logic        empty
);

  logic [63:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign push     = in_valid & ~full;
  assign pop      = out_ready & ~empty;
  assign out_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/gcd_axi_loader.sv
// AXI4 burst initiator: one local command becomes one INCR burst write or read.
// state | meaning
// IDLE  | waiting for a command
// AW/AR | address phase, valid held until ready
// WD    | write beats streamed from the skid buffer
// WB    | waiting for the write response
// RD    | read beats passed straight through to the sink
// RPT   | one-cycle completion report
module gcd_axi_loader
  import gcd_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID    = 4'h0,
  parameter int         MAX_BEATS = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [31:0] CMD_ADDR,
  input  logic [7:0]  CMD_LEN,
  input  logic [63:0] WR_DATA,
  input  logic        WR_VALID,
  output logic        WR_READY,
  output logic [63:0] RD_DATA,
  output logic        RD_VALID,
  input  logic        RD_READY,
  output logic        RD_LAST,
  output logic        DONE_VALID,
  output logic [1:0]  DONE_RESP,
  output logic        DONE_ERR,
  output logic [3:0]  M_AXI_AWID,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic        M_AXI_AWLOCK,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [3:0]  M_AXI_BID,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [3:0]  M_AXI_ARID,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic        M_AXI_ARLOCK,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [3:0]  M_AXI_RID,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  loader_state_t state, state_nxt;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [8:0]  src_cnt;
  logic [7:0]  w_cnt;
  logic [7:0]  r_cnt;
  logic [1:0]  resp_q;
  logic        err_q;
  logic [14:0] burst_end;
  logic        cmd_ok, cmd_fire, src_gate, src_fire, w_fire, b_fire, r_fire;
  logic        sk_full, sk_empty;

  // End of burst within its 4 KB page; must not pass 4096
  assign burst_end = {3'b000, CMD_ADDR[11:0]} + {3'b000, ({1'b0, CMD_LEN} + 9'd1), 3'b000};
  assign cmd_ok    = (CMD_ADDR[2:0] == 3'b000) && ({1'b0, CMD_LEN} < 9'(MAX_BEATS))
                     && (burst_end <= 15'd4096);

  assign CMD_READY = (state == ST_IDLE) && !RESET;
  assign cmd_fire  = CMD_VALID & CMD_READY;

  assign src_gate  = (state == ST_WD) && (src_cnt <= {1'b0, len_q});
  assign WR_READY  = src_gate & ~sk_full;
  assign src_fire  = WR_VALID & WR_READY;

  gcd_axi_skid u_skid (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_data   (WR_DATA),
    .in_valid  (WR_VALID & src_gate),
    .out_ready (M_AXI_WREADY & (state == ST_WD)),
    .out_data  (M_AXI_WDATA),
    .full      (sk_full),
    .empty     (sk_empty)
  );

  assign M_AXI_WVALID = (state == ST_WD) && !sk_empty;
  assign M_AXI_WSTRB  = 8'hFF;
  assign M_AXI_WLAST  = (w_cnt == len_q);
  assign w_fire       = M_AXI_WVALID & M_AXI_WREADY;

  assign M_AXI_BREADY = (state == ST_WB);
  assign b_fire       = M_AXI_BVALID & M_AXI_BREADY;

  assign M_AXI_RREADY = (state == ST_RD) && RD_READY;
  assign RD_VALID     = (state == ST_RD) && M_AXI_RVALID;
  assign RD_DATA      = M_AXI_RDATA;
  assign RD_LAST      = (state == ST_RD) && (r_cnt == len_q);
  assign r_fire       = M_AXI_RVALID & M_AXI_RREADY;

  assign M_AXI_AWID    = AXI_ID;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = SIZE_8B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0000;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (state == ST_AW);

  assign M_AXI_ARID    = AXI_ID;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = SIZE_8B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state == ST_AR);

  assign DONE_VALID = (state == ST_RPT);
  assign DONE_RESP  = resp_q;
  assign DONE_ERR   = err_q;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_fire) state_nxt = !cmd_ok ? ST_RPT : (CMD_WRITE ? ST_AW : ST_AR);
      ST_AW:   if (M_AXI_AWREADY) state_nxt = ST_WD;
      ST_WD:   if (w_fire && M_AXI_WLAST) state_nxt = ST_WB;
      ST_WB:   if (b_fire) state_nxt = ST_RPT;
      ST_AR:   if (M_AXI_ARREADY) state_nxt = ST_RD;
      ST_RD:   if (r_fire && (r_cnt == len_q)) state_nxt = ST_RPT;
      ST_RPT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q  <= '0;
      len_q   <= '0;
      src_cnt <= '0;
      w_cnt   <= '0;
      r_cnt   <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= CMD_ADDR;
        len_q   <= CMD_LEN;
        src_cnt <= '0;
        w_cnt   <= '0;
        r_cnt   <= '0;
        resp_q  <= RESP_OKAY;
        err_q   <= ~cmd_ok;
      end
      if (src_fire) src_cnt <= src_cnt + 9'd1;
      if (w_fire)   w_cnt   <= w_cnt + 8'd1;
      if (b_fire) begin
        resp_q <= M_AXI_BRESP;
        err_q  <= (M_AXI_BID != AXI_ID);
      end
      // An early or missing RLAST is flagged but never shortens the count
      if (r_fire) begin
        r_cnt  <= r_cnt + 8'd1;
        resp_q <= resp_worst(resp_q, M_AXI_RRESP);
        if ((M_AXI_RID != AXI_ID) || (M_AXI_RLAST != (r_cnt == len_q))) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gcd_axi_loader.sv
// Bench for gcd_axi_loader: bus slave and local stream models with a data scoreboard.
module tb_gcd_axi_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 0, CMD_WRITE = 0;
  logic [31:0] CMD_ADDR = '0;
  logic [7:0]  CMD_LEN = '0;
  logic        CMD_READY;
  logic [63:0] WR_DATA = '0;
  logic        WR_VALID = 0, WR_READY;
  logic [63:0] RD_DATA;
  logic        RD_VALID, RD_LAST;
  logic        RD_READY = 0;
  logic        DONE_VALID, DONE_ERR;
  logic [1:0]  DONE_RESP;
  logic [3:0]  AWID, ARID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST;
  logic        AWLOCK, ARLOCK;
  logic [3:0]  AWCACHE, ARCACHE;
  logic        AWVALID, ARVALID;
  logic        AWREADY = 0, ARREADY = 0;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID;
  logic        WREADY = 0;
  logic [3:0]  BID = '0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 0, BREADY;
  logic [3:0]  RID = '0;
  logic [63:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 0, RVALID = 0, RREADY;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  gcd_axi_loader #(.AXI_ID(4'h0), .MAX_BEATS(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_LAST(RD_LAST),
    .DONE_VALID(DONE_VALID), .DONE_RESP(DONE_RESP), .DONE_ERR(DONE_ERR),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE),
    .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
    .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARCACHE(ARCACHE),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Tasks start and end at posedge+1; inputs change there, outputs are sampled at posedge+2.
  task automatic wait_ready();
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (CMD_READY !== 1'b1) $display("FAIL cmd_ready_wait: got %b want 1", CMD_READY);
    else passed++;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input bit stall,
                           input logic [1:0] bresp, input logic [3:0] bid);
    logic [63:0] sb[$];
    logic [63:0] exp_d, prev_d;
    logic [1:0]  d_resp = 2'bxx;
    logic        d_err = 1'bx;
    int src_n = 0, w_n = 0, stall_cnt = 0;
    int acc_c = -100, aw1_c = -1, w1_c = -1, b_c = -1, done_c = -1;
    bit accepted = 0, aw_done = 0, b_done = 0, fin = 0, prev_stall = 0, early_w = 0, src_hs;
    wait_ready();
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = addr; CMD_LEN = len;
    WR_VALID = 1; WR_DATA = {$urandom, $urandom};
    AWREADY = 1; WREADY = 1; BVALID = 0; BRESP = bresp; BID = bid;
    for (int t = 0; t < 400 && !fin; t++) begin
      if (stall) WREADY = !(WVALID && (w_n % 2 == 1) && stall_cnt < 3);
      BVALID = (w_n == int'(len) + 1) && !b_done;
      #1;
      if (!aw_done && WVALID) early_w = 1;
      if (prev_stall) begin
        checks++;
        if (WVALID !== 1'b1 || WDATA !== prev_d)
          $display("FAIL w_stable beat %0d: got v=%b d=%h want v=1 d=%h", w_n, WVALID, WDATA, prev_d);
        else passed++;
      end
      if (CMD_VALID && CMD_READY) begin accepted = 1; acc_c = cyc; end
      if (AWVALID && aw1_c < 0) aw1_c = cyc;
      if (AWVALID && AWREADY) begin
        aw_done = 1;
        checks++;
        if ({AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT} !==
            {4'h0, addr, len, 3'b011, 2'b01, 1'b0, 4'h0, 3'h0})
          $display("FAIL aw_fields: got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d size=3 burst=1",
                   AWADDR, AWLEN, AWSIZE, AWBURST, addr, len);
        else passed++;
      end
      src_hs = WR_VALID && WR_READY;
      if (src_hs) begin sb.push_back(WR_DATA); src_n++; end
      if (WVALID && w1_c < 0) w1_c = cyc;
      if (WVALID && WREADY) begin
        if (sb.size() > 0) exp_d = sb.pop_front(); else exp_d = 'x;
        checks++;
        if (WDATA !== exp_d || WSTRB !== 8'hFF)
          $display("FAIL wdata beat %0d: got %h strb %h want %h strb ff", w_n, WDATA, WSTRB, exp_d);
        else passed++;
        checks++;
        if (WLAST !== (w_n == int'(len)))
          $display("FAIL wlast beat %0d: got %b want %b", w_n, WLAST, w_n == int'(len));
        else passed++;
        w_n++;
        stall_cnt = 0;
      end
      prev_stall = WVALID && !WREADY;
      prev_d = WDATA;
      if (prev_stall) stall_cnt++;
      if (BVALID && BREADY) begin b_c = cyc; b_done = 1; end
      if (DONE_VALID) begin done_c = cyc; d_resp = DONE_RESP; d_err = DONE_ERR; fin = 1; end
      @(posedge CLK); #1;
      if (accepted) CMD_VALID = 0;
      if (src_hs) WR_DATA = {$urandom, $urandom};
    end
    BVALID = 0; WR_VALID = 0;
    checks++;
    if (!fin) $display("FAIL write_timeout: got no DONE_VALID want DONE_VALID");
    else passed++;
    checks++;
    if (d_resp !== bresp || d_err !== (bid != 4'h0))
      $display("FAIL write_done: got resp=%0d err=%b want resp=%0d err=%b", d_resp, d_err, bresp, bid != 4'h0);
    else passed++;
    checks++;
    if (src_n != int'(len) + 1 || w_n != int'(len) + 1 || early_w)
      $display("FAIL write_counts: got src=%0d w=%0d early=%b want src=%0d w=%0d early=0",
               src_n, w_n, early_w, len + 1, len + 1);
    else passed++;
    checks++;
    if (aw1_c != acc_c + 1 || w1_c < acc_c + 2 || w1_c > acc_c + 3 || done_c != b_c + 1)
      $display("FAIL write_latency: got aw=%0d w=%0d done=%0d want aw=%0d w=%0d..%0d done=%0d",
               aw1_c - acc_c, w1_c - acc_c, done_c, 1, 2, 3, b_c + 1);
    else passed++;
    checks++;
    if (CMD_READY !== 1'b1 || DONE_VALID !== 1'b0)
      $display("FAIL write_next_ready: got ready=%b done=%b want ready=1 done=0", CMD_READY, DONE_VALID);
    else passed++;
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle,
                          input int resp_beat, input int early_last,
                          input logic [1:0] exp_resp, input logic exp_err);
    logic [63:0] sb[$];
    logic [63:0] rd_d = '0, exp_d;
    logic [1:0]  d_resp = 2'bxx;
    logic        d_err = 1'bx;
    int r_n = 0, acc_c = -100, ar1_c = -1, last_c = -1, done_c = -1;
    bit accepted = 0, ar_done = 0, presented = 0, fin = 0;
    wait_ready();
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = addr; CMD_LEN = len;
    ARREADY = 1; RVALID = 0; RD_READY = 1; RID = 4'h0;
    for (int t = 0; t < 400 && !fin; t++) begin
      if (ar_done && r_n <= int'(len)) begin
        if (!presented) begin
          rd_d = {$urandom, $urandom};
          sb.push_back(rd_d);
          presented = 1;
        end
        RVALID = 1; RDATA = rd_d;
        RRESP = (r_n == resp_beat) ? 2'd3 : 2'd0;
        RLAST = (r_n == int'(len)) || (r_n == early_last);
      end else begin
        RVALID = 0; RLAST = 0; RRESP = 2'd0;
      end
      if (toggle) RD_READY = (t % 2 == 0);
      #1;
      if (CMD_VALID && CMD_READY) begin accepted = 1; acc_c = cyc; end
      if (ARVALID && ar1_c < 0) ar1_c = cyc;
      if (ARVALID && ARREADY) begin
        ar_done = 1;
        checks++;
        if ({ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT} !==
            {4'h0, addr, len, 3'b011, 2'b01, 1'b0, 4'h0, 3'h0})
          $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d size=3 burst=1",
                   ARADDR, ARLEN, ARSIZE, ARBURST, addr, len);
        else passed++;
      end
      if (RD_VALID && RD_READY) begin
        if (sb.size() > 0) exp_d = sb.pop_front(); else exp_d = 'x;
        checks++;
        if (RD_DATA !== exp_d || RREADY !== 1'b1)
          $display("FAIL rd_data beat %0d: got %h rready=%b want %h rready=1", r_n, RD_DATA, RREADY, exp_d);
        else passed++;
        checks++;
        if (RD_LAST !== (r_n == int'(len)))
          $display("FAIL rd_last beat %0d: got %b want %b", r_n, RD_LAST, r_n == int'(len));
        else passed++;
        r_n++;
        presented = 0;
        last_c = cyc;
      end
      if (DONE_VALID) begin done_c = cyc; d_resp = DONE_RESP; d_err = DONE_ERR; fin = 1; end
      @(posedge CLK); #1;
      if (accepted) CMD_VALID = 0;
    end
    RVALID = 0; RLAST = 0; RD_READY = 0;
    checks++;
    if (!fin) $display("FAIL read_timeout: got no DONE_VALID want DONE_VALID");
    else passed++;
    checks++;
    if (d_resp !== exp_resp || d_err !== exp_err)
      $display("FAIL read_done: got resp=%0d err=%b want resp=%0d err=%b", d_resp, d_err, exp_resp, exp_err);
    else passed++;
    checks++;
    if (r_n != int'(len) + 1 || ar1_c != acc_c + 1 || done_c != last_c + 1)
      $display("FAIL read_counts: got beats=%0d ar=%0d done=%0d want beats=%0d ar=1 done=%0d",
               r_n, ar1_c - acc_c, done_c, len + 1, last_c + 1);
    else passed++;
    checks++;
    if (CMD_READY !== 1'b1)
      $display("FAIL read_next_ready: got %b want 1", CMD_READY);
    else passed++;
  endtask

  task automatic run_reject(input logic [31:0] addr, input logic [7:0] len, input logic wr);
    int acc_c = -100, done_c = -1;
    logic [1:0] d_resp = 2'bxx;
    logic d_err = 1'bx;
    bit accepted = 0, bad = 0;
    wait_ready();
    CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_LEN = len;
    AWREADY = 1; ARREADY = 1;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (CMD_VALID && CMD_READY) begin accepted = 1; acc_c = cyc; end
      if (AWVALID || ARVALID) bad = 1;
      if (DONE_VALID && done_c < 0) begin done_c = cyc; d_resp = DONE_RESP; d_err = DONE_ERR; end
      @(posedge CLK); #1;
      if (accepted) CMD_VALID = 0;
    end
    checks++;
    if (done_c < 0 || done_c - acc_c > 2)
      $display("FAIL reject_latency addr=%h len=%0d: got %0d want <=2", addr, len, done_c - acc_c);
    else passed++;
    checks++;
    if (d_err !== 1'b1 || d_resp !== 2'd0 || bad)
      $display("FAIL reject_status addr=%h len=%0d: got err=%b resp=%0d bus=%b want err=1 resp=0 bus=0",
               addr, len, d_err, d_resp, bad);
    else passed++;
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if ({CMD_READY, AWVALID, WVALID, BREADY, ARVALID, RREADY, WR_READY, RD_VALID,
         DONE_VALID, DONE_RESP, DONE_ERR} !== 12'h000)
      $display("FAIL reset_outputs: got rdy=%b aw=%b w=%b b=%b ar=%b r=%b wr=%b rd=%b done=%b resp=%0d err=%b want all 0",
               CMD_READY, AWVALID, WVALID, BREADY, ARVALID, RREADY, WR_READY, RD_VALID,
               DONE_VALID, DONE_RESP, DONE_ERR);
    else passed++;
    @(posedge CLK); #1;
    RESET = 0;
    @(posedge CLK); #1;
    checks++;
    if (CMD_READY !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", CMD_READY);
    else passed++;
  endtask

  task automatic test_write_basic();
    run_write(32'h0000_0000, 8'd19, 0, 2'd0, 4'h0);
  endtask

  task automatic test_read_toggle();
    run_read(32'h0000_0100, 8'd20, 1, -1, -1, 2'd0, 1'b0);
  endtask

  task automatic test_write_stall();
    run_write(32'h0000_0200, 8'd19, 1, 2'd0, 4'h0);
  endtask

  task automatic test_error_resp();
    run_write(32'h0000_0400, 8'd3, 0, 2'd2, 4'h0);
    run_read(32'h0000_0500, 8'd20, 0, 6, -1, 2'd3, 1'b0);
    run_write(32'h0000_0600, 8'd1, 0, 2'd0, 4'h3);
  endtask

  task automatic test_reject();
    run_reject(32'h0000_0004, 8'd0, 1'b1);
    run_reject(32'h0000_0FF8, 8'd1, 1'b1);
    run_reject(32'h0000_0000, 8'd40, 1'b0);
  endtask

  task automatic test_boundary();
    run_write(32'h0000_0FF8, 8'd0, 0, 2'd0, 4'h0);
    run_read(32'h0000_0000, 8'd31, 0, -1, -1, 2'd0, 1'b0);
  endtask

  task automatic test_early_rlast();
    run_read(32'h0000_0100, 8'd20, 0, -1, 4, 2'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen_w = 0, accepted = 0;
    wait_ready();
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h0; CMD_LEN = 8'd19;
    WR_VALID = 1; WR_DATA = {$urandom, $urandom}; AWREADY = 1; WREADY = 0;
    for (int t = 0; t < 20 && !seen_w; t++) begin
      #1;
      if (CMD_VALID && CMD_READY) accepted = 1;
      if (WVALID) seen_w = 1;
      else begin
        @(posedge CLK); #1;
        if (accepted) CMD_VALID = 0;
      end
    end
    CMD_VALID = 0;
    checks++;
    if (!seen_w) $display("FAIL reset_mid_reach_wd: got no WVALID want WVALID");
    else passed++;
    RESET = 1;
    @(posedge CLK); #1;
    checks++;
    if ({CMD_READY, AWVALID, WVALID, BREADY, ARVALID, RREADY, WR_READY, RD_VALID, DONE_VALID} !== 9'h000)
      $display("FAIL reset_mid_valids: got aw=%b w=%b b=%b ar=%b r=%b wr=%b done=%b rdy=%b want all 0",
               AWVALID, WVALID, BREADY, ARVALID, RREADY, WR_READY, DONE_VALID, CMD_READY);
    else passed++;
    RESET = 0; WR_VALID = 0; WREADY = 1;
    @(posedge CLK); #1;
    checks++;
    if (CMD_READY !== 1'b1) $display("FAIL reset_mid_ready: got %b want 1", CMD_READY);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_write(32'h0000_0800, 8'd3, 0, 2'd0, 4'h0);
    run_write(32'h0000_0900, 8'd4, 1, 2'd0, 4'h0);
    run_read(32'h0000_0A00, 8'd2, 1, -1, -1, 2'd0, 1'b0);
  endtask

  initial begin
    #1;
    test_reset();
    test_write_basic();
    test_read_toggle();
    test_write_stall();
    test_error_resp();
    test_reject();
    test_boundary();
    test_early_rlast();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $display("%0d/%0d checks passed", passed, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/gcd_axi_loader.md
Name: gcd_axi_loader

Overview:
- AXI4 burst initiator that pairs with the GCD wrapper's AXI data slave.
- A local controller (test sequencer or host bridge) issues one command per transfer:
  - burst-write operand beats (ARG_A/ARG_B, 20 beats each), or
  - burst-read result and debug beats (BEZOUT_*/DEBUG_*, 21 beats each).
- Write data comes from a local valid/ready source stream. Read data goes to a local sink stream.
- A completion pulse reports the bus status of each transfer.

Parameters:
- AXI_ID, 4'h0, constant driven on AWID/ARID; also the value expected on BID/RID.
- MAX_BEATS, 32, largest accepted burst length in beats (CMD_LEN+1); range 1..256.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD_WRITE  in  1  1 = burst write, 0 = burst read.
- CMD_ADDR  in  32  byte address; must be 8-byte aligned.
- CMD_LEN  in  8  beats minus 1.
- WR_DATA  in  64  source stream data.
- WR_VALID  in  1  source stream valid.
- WR_READY  out  1  source stream ready.
- RD_DATA  out  64  sink stream data.
- RD_VALID  out  1  sink stream valid.
- RD_READY  in  1  sink stream ready.
- RD_LAST  out  1  marks the final sink beat.
- DONE_VALID  out  1  one-cycle completion pulse.
- DONE_RESP  out  2  worst BRESP/RRESP of the transfer.
- DONE_ERR  out  1  command rejected or protocol mismatch.
- M_AXI_AW*: AWID 4, AWADDR 32, AWLEN 8, AWSIZE 3, AWBURST 2, AWLOCK 1, AWCACHE 4, AWPROT 3, AWVALID out; AWREADY in.
- M_AXI_W*: WDATA 64, WSTRB 8, WLAST 1, WVALID out; WREADY in.
- M_AXI_B*: BID 4, BRESP 2, BVALID in; BREADY out.
- M_AXI_AR*: same fields and widths as AW*, out; ARREADY in.
- M_AXI_R*: RID 4, RDATA 64, RRESP 2, RLAST 1, RVALID in; RREADY out.

Behaviour:
- Reset values:
  - All VALID outputs, BREADY, RREADY, WR_READY, CMD_READY, DONE_VALID = 0.
  - DONE_RESP = 0, DONE_ERR = 0.
  - FSM in IDLE; beat counters = 0; skid buffer empty.
  - CMD_READY rises the first cycle after RESET deasserts.
- Reset mid-transfer: all valids drop at the next edge. No bus cleanup is performed; the slave is reset by the same system reset.
- Constant fields:
  - SIZE = 3'b011, BURST = INCR (2'b01), LOCK = 0, CACHE = 4'b0000, PROT = 3'b000.
  - WSTRB = 8'hFF; ID = AXI_ID.
  - ADDR and LEN are registered from the command.
- Command checks on acceptance (any failure → no bus traffic; go to RPT with DONE_ERR = 1 and DONE_RESP = 0):
  - CMD_ADDR[2:0] must be 0.
  - CMD_LEN+1 must not exceed MAX_BEATS.
  - The burst must not cross 4 KB, i.e. CMD_ADDR[11:0] + 8·(CMD_LEN+1) must be ≤ 4096.
- FSM states: IDLE, AW, WD, WB, AR, RD, RPT.
- IDLE:
  - CMD_VALID & CMD_READY → AW (write), AR (read), or RPT (rejected).
  - AWVALID/ARVALID is asserted the cycle after acceptance.
- AW: hold AWVALID with stable fields until AWREADY; then → WD. W beats are never presented before the AW handshake.
- WD, source side:
  - Source beats enter a 2-entry skid buffer.
  - WR_READY = in WD, buffer not full, and source count ≤ CMD_LEN. Exactly CMD_LEN+1 source beats are taken.
- WD, bus side:
  - M_AXI_WVALID = buffer not empty; data comes from the buffer head.
  - The W counter increments on each WVALID & WREADY.
  - WLAST = 1 when the W counter equals CMD_LEN.
  - The handshake on the WLAST beat → WB.
  - WVALID and WDATA stay stable while WREADY is low.
- WB:
  - BREADY = 1.
  - On handshake, DONE_RESP = BRESP; DONE_ERR = (BID ≠ AXI_ID).
  - Then → RPT.
- AR: same rules as AW; → RD after the ARREADY handshake.
- RD:
  - RREADY = RD_READY; RD_VALID = RVALID; RD_DATA = RDATA (combinational pass-through).
  - RD_LAST = 1 when the R counter equals CMD_LEN.
  - Each handshake folds RRESP into DONE_RESP as a running maximum (DECERR 3 > SLVERR 2 > OKAY 0).
  - DONE_ERR is set if RID ≠ AXI_ID, or RLAST ≠ (R counter equals CMD_LEN) on any beat.
  - The final counted beat ends the transfer → RPT. An early RLAST does not end it; counting continues to CMD_LEN+1 beats.
- RPT:
  - DONE_VALID = 1 for exactly one cycle, then → IDLE.
  - DONE_RESP/DONE_ERR hold until the next command is accepted, then clear.
- Latency, write of N beats with an always-ready slave and source:
  - Command accept at cycle 0, AWVALID at cycle 1.
  - First WVALID at cycle 2 or 3.
  - DONE_VALID one cycle after the B handshake.
- Simultaneous events:
  - A skid-buffer push and pop in the same cycle keep the occupancy unchanged.
  - Back-to-back commands: the next CMD_READY is high in the cycle after DONE_VALID.

Decomposition:
- Shared package gcd_axi_pkg:
  - Burst type, SIZE and resp code constants (OKAY/EXOKAY/SLVERR/DECERR).
  - Loader FSM state enum.
  - Beat counts for 1279-bit operands (20) and 1284-bit results (21).
- One sub-module, gcd_axi_skid: 2-entry valid/ready buffer, 64-bit data, full/empty flags, registered outputs.

Test Plan:
- Write, addr 0x0000_0000, LEN 19, slave and source always ready:
  - AWLEN = 19, AWSIZE = 3, AWBURST = 1; exactly 20 W beats.
  - WLAST only on beat 20.
  - One DONE_VALID with DONE_RESP = 0 and DONE_ERR = 0.
- Read, addr 0x0000_0100, LEN 20, RD_READY toggling 1-0-1:
  - 21 sink beats in RDATA order; RD_LAST on beat 21; DONE_RESP = 0.
- Write with slave WREADY low for 3 cycles on each even beat:
  - WDATA/WVALID stable throughout each stall.
  - No beat lost or duplicated; source count = 20.
- Error responses:
  - BRESP = 2 → DONE_RESP = 2.
  - Read with RRESP = 3 on beat 7 of 21 → DONE_RESP = 3 after all 21 beats.
- Rejected commands, each → DONE_VALID within 2 cycles, DONE_ERR = 1, no AWVALID/ARVALID ever asserted:
  - CMD_ADDR = 0x4.
  - CMD_ADDR = 0xFF8 with LEN 1.
  - CMD_LEN = 40 with MAX_BEATS = 32.
- Protocol faults and reset:
  - RLAST on beat 5 of 21 → DONE_ERR = 1 after 21 beats.
  - RESET asserted mid-WD → all valids 0 next cycle; CMD_READY = 1 one cycle after RESET deasserts.
